mem_port_arbiter: RTL

Single-port memory arbiter for the pipelined RV core: multiplexes instruction fetch and load/store traffic onto one shared memory bus with a req/ack handshake and multi-cycle memory latency. Performs byte-lane alignment for stores and sign/zero extension for loads, and detects misaligned accesses. Sits between the fetch/data stages and the external memory. Generates `mem_stall` so the pipeline freezes while a data access is outstanding.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 83 ++++++++
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM state codes, RV funct3
// size/sign codes and the instruction returned when a fetch times out.
// Imported by mem_lane_align and mem_port_arbiter.
package mem_arb_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // RV load/store size and sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // addi x0, x0, 0 -- handed to the fetch stage when the bus never answers
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: store data replication and byte
// enables, load extraction with sign/zero extension, misalignment/illegal flag.
// Purely combinational, zero latency, no flow control.
module mem_lane_align
  import mem_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [2:0]        i_addr_lo,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN/8-1:0] o_be,
  output logic [XLEN-1:0]   o_ld_data,
  output logic              o_misaligned
);

  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);

  logic [LB-1:0]   w_lane;
  logic [XLEN-1:0] w_shifted;

  assign w_lane    = i_addr_lo[LB-1:0];
  // Bring the addressed byte down to lane 0 before extension
  assign w_shifted = i_rdata >> {w_lane, 3'b000};

  // Store path: replicate the operand over every lane and enable only the
  // addressed bytes; also flags misaligned or size codes illegal for this XLEN
  always_comb begin
    o_wdata      = '0;
    o_be         = '0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B: begin
        for (int i = 0; i < NB; i++) o_wdata[i*8 +: 8] = i_wdata[7:0];
        o_be = NB'(1) << w_lane;
      end
      F3_H: begin
        for (int i = 0; i < NB / 2; i++) o_wdata[i*16 +: 16] = i_wdata[15:0];
        o_be         = NB'(2'b11) << w_lane;
        o_misaligned = i_addr_lo[0];
      end
      F3_W: begin
        for (int i = 0; i < NB / 4; i++) o_wdata[i*32 +: 32] = i_wdata[31:0];
        o_be         = NB'(4'hF) << w_lane;
        o_misaligned = |i_addr_lo[1:0];
      end
      F3_D: begin
        if (XLEN == 64) begin
          o_wdata      = i_wdata;
          o_be         = '1;
          o_misaligned = |i_addr_lo[2:0];
        end else begin
          o_misaligned = 1'b1;
        end
      end
      // Unsigned codes have no store form
      F3_BU:   o_misaligned = i_we;
      F3_HU:   o_misaligned = i_we | i_addr_lo[0];
      F3_WU:   o_misaligned = (XLEN != 64) | i_we | (|i_addr_lo[1:0]);
      default: o_misaligned = 1'b1;
    endcase
  end

  // Load path: extend the selected byte/half/word to XLEN
  always_comb begin
    o_ld_data = '0;
    case (i_funct3)
      F3_B:    o_ld_data = XLEN'($signed(w_shifted[7:0]));
      F3_BU:   o_ld_data = XLEN'(w_shifted[7:0]);
      F3_H:    o_ld_data = XLEN'($signed(w_shifted[15:0]));
      F3_HU:   o_ld_data = XLEN'(w_shifted[15:0]);
      F3_W:    o_ld_data = XLEN'($signed(w_shifted[31:0]));
      F3_WU:   o_ld_data = XLEN'(w_shifted[31:0]);
      F3_D:    o_ld_data = w_shifted;
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port beats fetch, one bus transaction at a time.
// Latency: grant c0, m_req c1, rvalid one cycle after m_ack (misaligned data: c1).
// Requesters hold *_req until *_gnt; bus holds off via m_ack; optional watchdog
// under `MEM_ARB_TIMEOUT_EN` aborts a cycle after TIMEOUT_CYCLES without m_ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                XLEN           = 32,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] DATA_BASE      = 32'h8000_0000,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err,
  output logic              mem_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [XLEN/8-1:0] m_be,
  output logic [XLEN-1:0]   m_wdata,
  input  logic              m_ack,
  input  logic [XLEN-1:0]   m_rdata
);

  // Shift that selects the addressed 32-bit instruction lane on a 64-bit bus
  localparam int FSH = (XLEN == 64) ? 32 : 0;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_wdata;
  logic              r_is_data;
  logic              r_err;
  logic              r_flush;
  logic              r_m_req;
  logic [XLEN-1:0]   r_d_rdata;
  logic [31:0]       r_f_rdata;

  logic              w_idle;
  logic              w_al_we;
  logic [2:0]        w_al_funct3;
  logic [2:0]        w_al_addr_lo;
  logic [XLEN-1:0]   w_st_wdata;
  logic [XLEN/8-1:0] w_st_be;
  logic [XLEN-1:0]   w_ld_data;
  logic              w_misal;
  logic [31:0]       w_f_word;

  assign w_idle = (r_state == ST_IDLE);

  // In IDLE the aligner judges the live request; afterwards it works on the
  // latched copy so bus outputs stay stable across wait states
  assign w_al_we      = w_idle ? d_we        : r_we;
  assign w_al_funct3  = w_idle ? d_funct3    : r_funct3;
  assign w_al_addr_lo = w_idle ? d_addr[2:0] : r_addr[2:0];

  mem_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_we         (w_al_we),
    .i_funct3     (w_al_funct3),
    .i_addr_lo    (w_al_addr_lo),
    .i_wdata      (r_wdata),
    .i_rdata      (m_rdata),
    .o_wdata      (w_st_wdata),
    .o_be         (w_st_be),
    .o_ld_data    (w_ld_data),
    .o_misaligned (w_misal)
  );

  assign w_f_word = 32'(r_addr[2] ? (m_rdata >> FSH) : m_rdata);

  // Grants are combinational from IDLE; data always has priority
  assign d_gnt = w_idle & ~reset & d_req;
  assign f_gnt = w_idle & ~reset & ~d_req & f_req;

  // Bus outputs are forced to zero whenever no request is on the bus
  assign m_req   = r_m_req;
  assign m_we    = r_m_req & r_we;
  assign m_addr  = r_m_req ? r_addr : '0;
  assign m_be    = !r_m_req ? '0 : (r_is_data && r_we) ? w_st_be : '1;
  assign m_wdata = (r_m_req && r_we) ? w_st_wdata : '0;

  // A flush seen during RESP still kills the pulse in the same cycle
  assign f_rvalid  = (r_state == ST_RESP) & ~r_is_data & ~r_flush & ~f_flush;
  assign f_rdata   = r_f_rdata;
  assign d_rvalid  = (r_state == ST_RESP) & r_is_data;
  assign d_err     = d_rvalid & r_err;
  assign d_rdata   = r_d_rdata;
  assign mem_stall = d_req | (r_state == ST_DATA) | ((r_state == ST_RESP) & r_is_data);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          w_tmo_hit;

  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Ack watchdog: zero outside bus cycles, counts every cycle spent waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_FETCH || r_state == ST_DATA) begin
      if (!m_ack) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Main FSM: arbitration, request latching, bus handshake, response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_funct3  <= '0;
      r_wdata   <= '0;
      r_is_data <= 1'b0;
      r_err     <= 1'b0;
      r_flush   <= 1'b0;
      r_m_req   <= 1'b0;
      r_d_rdata <= '0;
      r_f_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (d_req) begin
            r_addr    <= d_addr | DATA_BASE;
            r_we      <= d_we;
            r_funct3  <= d_funct3;
            r_wdata   <= d_wdata;
            r_is_data <= 1'b1;
            r_flush   <= 1'b0;
            if (w_misal) begin
              // Granted but never put on the bus
              r_err     <= 1'b1;
              r_d_rdata <= '0;
              r_state   <= ST_RESP;
            end else begin
              r_err     <= 1'b0;
              r_m_req   <= 1'b1;
              r_state   <= ST_DATA;
            end
          end else if (f_req) begin
            r_addr    <= f_addr;
            r_we      <= 1'b0;
            r_funct3  <= F3_W;
            r_is_data <= 1'b0;
            r_flush   <= 1'b0;
            r_err     <= 1'b0;
            r_m_req   <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH, ST_DATA: begin
          if (r_state == ST_FETCH && f_flush) r_flush <= 1'b1;
          if (m_ack) begin
            r_m_req <= 1'b0;
            r_state <= ST_RESP;
            if (r_is_data) r_d_rdata <= r_we ? '0 : w_ld_data;
            else           r_f_rdata <= w_f_word;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_m_req <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
            if (r_is_data) r_d_rdata <= '0;
            else           r_f_rdata <= NOP_INSN;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
